// File: rtl/pool2d_stream_if.sv
// Pooling stream bundle: pixel input side and pooled output side.
// slave is the pooling stage, master is whatever feeds and drains it.
interface pool2d_stream_if #(
  parameter int WIDTH_BIT = 16,
  parameter int CHANNELS  = 1
);
  logic                          in_valid;
  logic                          in_ready;
  logic [CHANNELS*WIDTH_BIT-1:0] in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [CHANNELS*WIDTH_BIT-1:0] out_data;
  logic                          out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pool2d_stream.sv
// Streaming non-overlapping 2-D max/avg pooling over a raster feature map.
// One row of window accumulators is kept; no frame buffer is needed.
module pool2d_stream #(
  parameter int WIDTH_BIT   = 16,
  parameter int SIZE        = 24,
  parameter int SIZEPOOLING = 2,
  parameter int CHANNELS    = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clear,
  input  logic           mode,
  pool2d_stream_if.slave s,
  output logic           done
);
  localparam int SIZEOUT = SIZE / SIZEPOOLING;
  localparam int LP      = $clog2(SIZEPOOLING);
  localparam int AW      = WIDTH_BIT + 2 * LP;
  localparam int CW      = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int OW      = (SIZEOUT > 1) ? $clog2(SIZEOUT) : 1;
  localparam logic [CW-1:0] LASTC = CW'(SIZE - 1);

  if ((SIZE % SIZEPOOLING) != 0) begin : g_bad_size
    $error("pool2d_stream: SIZE must be a multiple of SIZEPOOLING");
  end
  if (SIZEPOOLING < 2 || SIZEPOOLING > 8 ||
      (SIZEPOOLING & (SIZEPOOLING - 1)) != 0) begin : g_bad_pool
    $error("pool2d_stream: SIZEPOOLING must be a power of two in 2..8");
  end

  logic [CW-1:0]         col, row;
  logic [OW-1:0]         oc;
  logic                  mode_q;
  logic                  accept, origin, first, complete, frame_end, avg;
  logic signed [AW-1:0]  acc [SIZEOUT][CHANNELS];
  logic signed [AW-1:0]  pe  [CHANNELS];
  logic signed [AW-1:0]  nv  [CHANNELS];
  logic signed [AW-1:0]  sh  [CHANNELS];
  logic [CHANNELS*WIDTH_BIT-1:0] res;

  assign s.in_ready = ~reset & (~s.out_valid | s.out_ready);
  assign accept     = s.in_valid & s.in_ready & ~clear;
  assign oc         = OW'(col >> LP);
  assign origin     = (col == '0) && (row == '0);
  assign first      = (col[LP-1:0] == '0) && (row[LP-1:0] == '0);
  assign complete   = (&col[LP-1:0]) && (&row[LP-1:0]);
  assign frame_end  = (col == LASTC) && (row == LASTC);
  // The first pixel of a frame uses the live mode, later pixels the latch.
  assign avg        = origin ? mode : mode_q;
  assign done       = s.out_valid & s.out_ready & s.out_last & ~clear;

  // Per-lane accumulator update and pooled result for the current pixel.
  always_comb begin
    res = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pe[c] = AW'(signed'(s.in_data[c*WIDTH_BIT +: WIDTH_BIT]));
      if (first)
        nv[c] = pe[c];
      else if (avg)
        nv[c] = acc[oc][c] + pe[c];
      else
        nv[c] = (pe[c] > acc[oc][c]) ? pe[c] : acc[oc][c];
      sh[c] = nv[c] >>> (2 * LP);
      res[c*WIDTH_BIT +: WIDTH_BIT] =
        avg ? sh[c][WIDTH_BIT-1:0] : nv[c][WIDTH_BIT-1:0];
    end
  end

  // Raster position counters and per-frame mode latch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col    <= '0;
      row    <= '0;
      mode_q <= 1'b0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (origin)
        mode_q <= mode;
      if (col == LASTC) begin
        col <= '0;
        row <= (row == LASTC) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Row of window accumulators, one slot per output column.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int o = 0; o < SIZEOUT; o++)
        for (int c = 0; c < CHANNELS; c++)
          acc[o][c] <= '0;
    end else if (accept) begin
      for (int c = 0; c < CHANNELS; c++)
        acc[oc][c] <= nv[c];
    end
  end

  // Output beat register: loads on window completion, drains on out_ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      s.out_last  <= 1'b0;
    end else if (clear) begin
      s.out_valid <= 1'b0;
      s.out_last  <= 1'b0;
    end else if (accept && complete) begin
      s.out_valid <= 1'b1;
      s.out_data  <= res;
      s.out_last  <= frame_end;
    end else if (s.out_ready) begin
      s.out_valid <= 1'b0;
      s.out_last  <= 1'b0;
    end
  end
endmodule
